// File: rtl/gfx_row_scheduler_if.sv
// Row write bus between the two game-logic requesters, the scheduler and the graphics block.
// The scheduler takes the slave side; requesters and the graphics block take the master side.
interface gfx_row_scheduler_if #(
  parameter int IDX_W = 5,
  parameter int WIDTH = 30
);
  logic             req0;
  logic [IDX_W-1:0] row0;
  logic [WIDTH-1:0] data0;
  logic             gnt0;

  logic             req1;
  logic [IDX_W-1:0] row1;
  logic [WIDTH-1:0] data1;
  logic             gnt1;

  logic [IDX_W-1:0] oIndex;
  logic [WIDTH-1:0] oData;

  modport master (
    output req0, row0, data0,
    output req1, row1, data1,
    input  gnt0, gnt1,
    input  oIndex, oData
  );

  modport slave (
    input  req0, row0, data0,
    input  req1, row1, data1,
    output gnt0, gnt1,
    output oIndex, oData
  );
endinterface

// File: rtl/gfx_row_scheduler.sv
// Round-robin scheduler for the gameboard row write port, with an atomic board-clear sequence.
// Optional macro CG_BLANK_GATE_EN: grants only at edges inside the blanking interval.
module gfx_row_scheduler #(
  parameter int ROWS  = 20,
  parameter int WIDTH = 30,
  parameter int IDX_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               blank,
  input  logic               clr,
  output logic               clr_busy,
  gfx_row_scheduler_if.slave bus,
  output logic [7:0]         drop_cnt
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [IDX_W-1:0] FIRST_ROW = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_ROW  = IDX_W'(ROWS - 1);
  localparam int unsigned      ROWS_U    = ROWS;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic [7:0]       drop_q, drop_d;

  logic             window;
  logic             elig0, elig1, any_elig;
  logic             pick;
  logic [IDX_W-1:0] sel_row;
  logic [WIDTH-1:0] sel_data;

`ifdef CG_BLANK_GATE_EN
  assign window = blank;
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign window       = 1'b1;
`endif

  function automatic logic legal_row(input logic [IDX_W-1:0] r);
    return (r != '0) && (32'(r) < ROWS_U);
  endfunction

  // A grant consumes the request, so a requester showing gnt this cycle is not eligible.
  assign elig0    = bus.req0 & ~gnt0_q;
  assign elig1    = bus.req1 & ~gnt1_q;
  assign any_elig = elig0 | elig1;

  // pick = 1 selects requester 1; the pointer only matters when both compete.
  assign pick     = (elig0 & elig1) ? ptr_q : elig1;
  assign sel_row  = pick ? bus.row1  : bus.row0;
  assign sel_data = pick ? bus.data1 : bus.data0;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    idx_d   = '0;
    data_d  = '0;
    busy_d  = 1'b0;
    drop_d  = drop_q;

    unique case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          idx_d   = FIRST_ROW;
          busy_d  = 1'b1;
        end else if (window && any_elig) begin
          ptr_d  = ~pick;
          gnt0_d = ~pick;
          gnt1_d = pick;
          if (legal_row(sel_row)) begin
            idx_d  = sel_row;
            data_d = sel_data;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end

      CLEAR: begin
        // The row currently on the bus doubles as the clear counter; clr and requests wait.
        if (idx_q == LAST_ROW) begin
          state_d = IDLE;
        end else begin
          idx_d  = idx_q + FIRST_ROW;
          busy_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.oIndex = idx_q;
  assign bus.oData  = data_q;
  assign clr_busy   = busy_q;
  assign drop_cnt   = drop_q;

  a_one_grant : assert property (@(posedge clk) disable iff (!rst) !(gnt0_q && gnt1_q));
  a_no_grant_in_clear : assert property (@(posedge clk) disable iff (!rst)
                                         busy_q |-> !(gnt0_q || gnt1_q));

endmodule

// File: tb/tb_gfx_row_scheduler.sv
// Self-checking bench for gfx_row_scheduler: directed scenarios with literal expectations plus
// a randomized phase, all compared every cycle against a queue-based behavioural model.
module tb_gfx_row_scheduler;
  localparam int ROWS  = 20;
  localparam int WIDTH = 30;
  localparam int IDX_W = 5;

  logic       clk;
  logic       rst;
  logic       blank;
  logic       clr;
  logic       clr_busy;
  logic [7:0] drop_cnt;

  gfx_row_scheduler_if #(.IDX_W(IDX_W), .WIDTH(WIDTH)) bus ();

  gfx_row_scheduler #(.ROWS(ROWS), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .blank    (blank),
    .clr      (clr),
    .clr_busy (clr_busy),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: outputs expected in the cycle after each edge.
  logic             m_g0, m_g1, m_busy;
  logic [IDX_W-1:0] m_idx;
  logic [WIDTH-1:0] m_data;
  logic [7:0]       m_drop;
  int               m_ptr;
  logic [IDX_W-1:0] clr_rows[$];

  always @(posedge clk or negedge rst) begin : model
    bit               e0, e1, win;
    int               who;
    logic [IDX_W-1:0] r;
    if (!rst) begin
      m_g0   <= 1'b0;
      m_g1   <= 1'b0;
      m_busy <= 1'b0;
      m_idx  <= '0;
      m_data <= '0;
      m_drop <= '0;
      m_ptr  <= 0;
      clr_rows.delete();
    end else begin
      m_g0   <= 1'b0;
      m_g1   <= 1'b0;
      m_busy <= 1'b0;
      m_idx  <= '0;
      m_data <= '0;
      if (m_busy) begin
        if (clr_rows.size() != 0) begin
          m_idx  <= clr_rows.pop_front();
          m_busy <= 1'b1;
        end
      end else if (clr) begin
        for (int k = 2; k < ROWS; k++) clr_rows.push_back(IDX_W'(k));
        m_idx  <= IDX_W'(1);
        m_busy <= 1'b1;
      end else begin
        e0 = bus.req0 && !m_g0;
        e1 = bus.req1 && !m_g1;
`ifdef CG_BLANK_GATE_EN
        win = blank;
`else
        win = 1'b1;
`endif
        if (win && (e0 || e1)) begin
          who = (e0 && e1) ? m_ptr : (e1 ? 1 : 0);
          m_ptr <= 1 - who;
          if (who == 1) m_g1 <= 1'b1;
          else          m_g0 <= 1'b1;
          r = (who == 1) ? bus.row1 : bus.row0;
          if (r >= 1 && int'(r) < ROWS) begin
            m_idx  <= r;
            m_data <= (who == 1) ? bus.data1 : bus.data0;
          end else if (m_drop < 8'd255) begin
            m_drop <= m_drop + 8'd1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    check("gnt0",     32'(bus.gnt0), 32'(m_g0));
    check("gnt1",     32'(bus.gnt1), 32'(m_g1));
    check("oIndex",   32'(bus.oIndex), 32'(m_idx));
    check("clr_busy", 32'(clr_busy), 32'(m_busy));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (m_idx != '0) check("oData", 32'(bus.oData), 32'(m_data));
  end

  function automatic logic [IDX_W-1:0] rand_row();
    int v;
    if ($urandom_range(0, 7) == 0) v = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(20, 31));
    else                           v = int'($urandom_range(1, 19));
    return IDX_W'(v);
  endfunction

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.row0 = '0; bus.data0 = '0;
    bus.req1 = 1'b0; bus.row1 = '0; bus.data1 = '0;
    clr = 1'b0;
    blank = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [WIDTH-1:0] da, db;
    int n;
    int exp_gnt1[4];
    int exp_row[4];
    exp_gnt1 = '{1, 0, 1, 0};
    exp_row  = '{7, 3, 7, 3};

    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset oIndex",   32'(bus.oIndex), 32'd0);
    check("reset oData",    32'(bus.oData), 32'd0);
    check("reset gnt",      32'({bus.gnt1, bus.gnt0}), 32'd0);
    check("reset clr_busy", 32'(clr_busy), 32'd0);
    check("reset drop_cnt", 32'(drop_cnt), 32'd0);
    tick();
    tick();
    rst = 1'b1;

    // Single request: grant with data in the next cycle, then idle.
    bus.req0 = 1'b1; bus.row0 = 5'd5; bus.data0 = 30'h1234567;
    tick();
    check("t1 gnt0",   32'(bus.gnt0), 32'd1);
    check("t1 oIndex", 32'(bus.oIndex), 32'd5);
    check("t1 oData",  32'(bus.oData), 32'h1234567);
    bus.req0 = 1'b0;
    tick();
    check("t1 idle oIndex", 32'(bus.oIndex), 32'd0);
    check("t1 idle gnt0",   32'(bus.gnt0), 32'd0);

    // Both held: grants alternate every cycle; pointer favours requester 1 after the last grant.
    bus.req0 = 1'b1; bus.row0 = 5'd3; bus.data0 = 30'h0AAAAAA;
    bus.req1 = 1'b1; bus.row1 = 5'd7; bus.data1 = 30'h1555555;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2 gnt1",   32'(bus.gnt1), 32'(exp_gnt1[i]));
      check("t2 gnt0",   32'(bus.gnt0), 32'(1 - exp_gnt1[i]));
      check("t2 oIndex", 32'(bus.oIndex), 32'(exp_row[i]));
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    tick();

    // Clear with requester 1 pending; a second clr mid-sequence is ignored.
    clr = 1'b1;
    bus.req1 = 1'b1; bus.row1 = 5'd9; bus.data1 = 30'h2BCDEF0;
    tick();
    clr = 1'b0;
    check("t3 busy",   32'(clr_busy), 32'd1);
    check("t3 row1",   32'(bus.oIndex), 32'd1);
    check("t3 data",   32'(bus.oData), 32'd0);
    check("t3 gnt1",   32'(bus.gnt1), 32'd0);
    for (int r = 2; r < ROWS; r++) begin
      clr = (r == 10);
      tick();
      check("t3 clear row",  32'(bus.oIndex), 32'(r));
      check("t3 clear busy", 32'(clr_busy), 32'd1);
      check("t3 clear gnt1", 32'(bus.gnt1), 32'd0);
    end
    clr = 1'b0;
    tick();
    check("t3 end oIndex", 32'(bus.oIndex), 32'd0);
    check("t3 end busy",   32'(clr_busy), 32'd0);
    check("t3 end gnt1",   32'(bus.gnt1), 32'd0);
    tick();
    check("t3 late gnt1",   32'(bus.gnt1), 32'd1);
    check("t3 late oIndex", 32'(bus.oIndex), 32'd9);
    check("t3 late oData",  32'(bus.oData), 32'h2BCDEF0);
    bus.req1 = 1'b0;
    tick();

    // Illegal rows: granted but no write; drop counter saturates.
    bus.req0 = 1'b1; bus.row0 = 5'd0; bus.data0 = 30'h3FFFFFF;
    tick();
    check("t4 gnt0 row0",   32'(bus.gnt0), 32'd1);
    check("t4 oIndex row0", 32'(bus.oIndex), 32'd0);
    check("t4 drop 1",      32'(drop_cnt), 32'd1);
    bus.row0 = 5'd20;
    tick();
    check("t4 gap gnt0", 32'(bus.gnt0), 32'd0);
    tick();
    check("t4 gnt0 row20",   32'(bus.gnt0), 32'd1);
    check("t4 oIndex row20", 32'(bus.oIndex), 32'd0);
    check("t4 drop 2",       32'(drop_cnt), 32'd2);
    bus.row0 = 5'd0;
    for (int i = 0; i < 600; i++) tick();
    check("t4 drop sat", 32'(drop_cnt), 32'd255);
    bus.req0 = 1'b0;
    tick();
    tick();

    // Randomized traffic with occasional clears and blanking toggles.
    for (int c = 0; c < 3000; c++) begin
      if (!bus.req0 || bus.gnt0) begin
        bus.req0  = ($urandom_range(0, 3) != 0);
        bus.row0  = rand_row();
        bus.data0 = WIDTH'($urandom);
      end
      if (!bus.req1 || bus.gnt1) begin
        bus.req1  = ($urandom_range(0, 3) != 0);
        bus.row1  = rand_row();
        bus.data1 = WIDTH'($urandom);
      end
      clr   = ($urandom_range(0, 59) == 0);
      blank = ($urandom_range(0, 1) == 1);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 25; i++) tick();

    // Reset in the middle of a clear aborts it at once.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    while (bus.oIndex != 5'd8 && n < 40) begin
      tick();
      n++;
    end
    check("t6 reached row 8", 32'(bus.oIndex), 32'd8);
    rst = 1'b0;
    #1;
    check("t6 rst oIndex", 32'(bus.oIndex), 32'd0);
    check("t6 rst busy",   32'(clr_busy), 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      check("t6 after oIndex", 32'(bus.oIndex), 32'd0);
      check("t6 after busy",   32'(clr_busy), 32'd0);
    end

`ifdef CG_BLANK_GATE_EN
    // Grants wait for blanking.
    blank = 1'b0;
    bus.req0 = 1'b1; bus.row0 = 5'd4; bus.data0 = 30'h0123456;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5 gated gnt0", 32'(bus.gnt0), 32'd0);
    end
    blank = 1'b1;
    tick();
    check("t5 blank gnt0",   32'(bus.gnt0), 32'd1);
    check("t5 blank oIndex", 32'(bus.oIndex), 32'd4);
    bus.req0 = 1'b0;
    tick();
    tick();
`endif

    da = bus.oData;
    db = da;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
